// File: rtl/pattern_leds_pkg.sv
// pattern_leds_pkg: shared encodings and helpers for the RGB LED pattern driver.
//   - mode encoding (SHIFT/FLASH/BOUNCE/FILL) and color encoding (R/G/B)
//   - switch and button bit positions
//   - limit_f(): prescaler compare value for a given speed select
package pattern_leds_pkg;

  // Animation modes, advanced in this order by the mode button
  localparam logic [1:0] MODE_SHIFT  = 2'd0;
  localparam logic [1:0] MODE_FLASH  = 2'd1;
  localparam logic [1:0] MODE_BOUNCE = 2'd2;
  localparam logic [1:0] MODE_FILL   = 2'd3;

  // Active color channel
  localparam logic [1:0] COL_RED   = 2'd0;
  localparam logic [1:0] COL_GREEN = 2'd1;
  localparam logic [1:0] COL_BLUE  = 2'd2;

  // Switch bus map {dir, sel[NB_SEL-1:0], enable}
  localparam int SW_EN      = 0;
  localparam int SW_SEL_LSB = 1;

  // Direction bit sits just above the speed-select field
  function automatic int sw_dir_idx(input int nb_sel);
    return SW_SEL_LSB + nb_sel;
  endfunction

  // Button bus map
  localparam int BTN_MODE  = 0;
  localparam int BTN_RED   = 1;
  localparam int BTN_GREEN = 2;
  localparam int BTN_BLUE  = 3;

  // Prescaler compare value: full-scale count shifted down so that the
  // highest select value gives the slowest rate.
  function automatic logic [31:0] limit_f(input int nb_count, input int nb_sel,
                                          input int s);
    logic [31:0] full;
    full = (nb_count >= 32) ? 32'hFFFF_FFFF : ((32'd1 << nb_count) - 32'd1);
    return full >> ((1 << nb_sel) - 1 - s);
  endfunction

endpackage

// File: rtl/pattern_leds_btn_debounce.sv
// btn_debounce: one raw asynchronous button -> single-cycle press pulse.
//   clk_i   : board clock
//   rst_ni  : asynchronous active-low reset
//   btn_i   : raw button level (asynchronous, may bounce)
//   press_o : 1-cycle pulse on a debounced rising edge
// The stable level moves only after DB_CYCLES consecutive cycles in which
// the synchronised level differs from it; any agreement restarts the count.
module btn_debounce #(
  parameter int DB_CYCLES = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_i,
  output logic press_o
);

  localparam int CW = (DB_CYCLES < 1) ? 1 : $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          stable_q, stable_d;
  logic          prev_q;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    if (sync2_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      stable_d = sync2_q;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      prev_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= btn_i;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      prev_q   <= stable_q;
      cnt_q    <= cnt_d;
    end
  end

  // Rising edge of the debounced level only; releases give nothing
  assign press_o = stable_q & ~prev_q;

endmodule

// File: rtl/pattern_leds.sv
// pattern_leds: parametrised RGB LED animation driver.
//   clock   : board clock
//   ck_rst  : asynchronous active-low reset
//   i_sw    : {dir, speed sel, enable}
//   i_btn   : {blue, green, red, next mode}, raw
//   o_led   : one-hot current mode
//   o_led_r/g/b : pattern on the selected color channel, others 0
module pattern_leds
  import pattern_leds_pkg::*;
#(
  parameter int N_LEDS    = 4,
  parameter int NB_SEL    = 2,
  parameter int NB_COUNT  = 14,
  parameter int NB_SW     = 4,
  parameter int NB_BTN    = 4,
  parameter int DB_CYCLES = 4
) (
  input  logic              clock,
  input  logic              ck_rst,
  input  logic [NB_SW-1:0]  i_sw,
  input  logic [NB_BTN-1:0] i_btn,
  output logic [3:0]        o_led,
  output logic [N_LEDS-1:0] o_led_r,
  output logic [N_LEDS-1:0] o_led_g,
  output logic [N_LEDS-1:0] o_led_b
);

  localparam int SwDir = sw_dir_idx(NB_SEL);
  localparam logic [N_LEDS-1:0] PatOne = N_LEDS'(1);
  localparam logic [N_LEDS-1:0] PatAll = {N_LEDS{1'b1}};

  // ---------------------------------------------------------------- buttons
  logic [NB_BTN-1:0] press;

  for (genvar i = 0; i < NB_BTN; i++) begin : g_btn
    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db (
      .clk_i  (clock),
      .rst_ni (ck_rst),
      .btn_i  (i_btn[i]),
      .press_o(press[i])
    );
  end

  // --------------------------------------------------------------- switches
  logic              en, dir;
  logic [NB_SEL-1:0] sel;
  logic [NB_COUNT-1:0] limit;

  assign en    = i_sw[SW_EN];
  assign dir   = i_sw[SwDir];
  assign sel   = i_sw[SW_SEL_LSB +: NB_SEL];
  assign limit = NB_COUNT'(limit_f(NB_COUNT, NB_SEL, int'(sel)));

  // ------------------------------------------------------------------ state
  logic [NB_COUNT-1:0] cnt_q, cnt_d;
  logic [1:0]          mode_q, mode_d, mode_nxt;
  logic [1:0]          color_q, color_d;
  logic [N_LEDS-1:0]   pat_q, pat_d;
  logic                bdir_q, bdir_d;   // 0 = left/up, 1 = right/down
  logic                tick;

  assign mode_nxt = mode_q + 2'd1;
  // Compare with >= so a select change that lowers the limit below the
  // running count still produces a tick instead of waiting for wrap.
  assign tick     = en && (cnt_q >= limit);

  always_comb begin
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    pat_d   = pat_q;
    bdir_d  = bdir_q;
    color_d = color_q;

    if (press[BTN_MODE]) begin
      // Mode press wins over a coincident tick
      mode_d = mode_nxt;
      cnt_d  = '0;
      bdir_d = 1'b0;
      case (mode_nxt)
        MODE_FLASH: pat_d = PatAll;
        MODE_FILL:  pat_d = '0;
        default:    pat_d = PatOne;
      endcase
    end else if (en) begin
      if (tick) begin
        cnt_d = '0;
        case (mode_q)
          MODE_SHIFT: begin
            if (!dir) pat_d = {pat_q[N_LEDS-2:0], pat_q[N_LEDS-1]};
            else      pat_d = {pat_q[0], pat_q[N_LEDS-1:1]};
          end
          MODE_FLASH: begin
            pat_d = (pat_q == PatAll) ? '0 : PatAll;
          end
          MODE_BOUNCE: begin
            // At an end the tick reverses and steps back in one go
            if (!bdir_q) begin
              if (pat_q[N_LEDS-1]) begin
                bdir_d = 1'b1;
                pat_d  = pat_q >> 1;
              end else begin
                pat_d  = pat_q << 1;
              end
            end else begin
              if (pat_q[0]) begin
                bdir_d = 1'b0;
                pat_d  = pat_q << 1;
              end else begin
                pat_d  = pat_q >> 1;
              end
            end
          end
          default: begin  // MODE_FILL
            if (pat_q == PatAll) pat_d = '0;
            else if (!dir)       pat_d = {pat_q[N_LEDS-2:0], 1'b1};
            else                 pat_d = {1'b1, pat_q[N_LEDS-1:1]};
          end
        endcase
      end else begin
        cnt_d = cnt_q + NB_COUNT'(1);
      end
    end

    // Exclusive color select, priority R > G > B
    if (press[BTN_RED])        color_d = COL_RED;
    else if (press[BTN_GREEN]) color_d = COL_GREEN;
    else if (press[BTN_BLUE])  color_d = COL_BLUE;
  end

  always_ff @(posedge clock or negedge ck_rst) begin
    if (!ck_rst) begin
      cnt_q   <= '0;
      mode_q  <= MODE_SHIFT;
      color_q <= COL_RED;
      pat_q   <= PatOne;
      bdir_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      color_q <= color_d;
      pat_q   <= pat_d;
      bdir_q  <= bdir_d;
    end
  end

  // ---------------------------------------------------------------- outputs
  // Registered from the state registers: one cycle behind them.
  logic [3:0]        led_q;
  logic [N_LEDS-1:0] r_q, g_q, b_q;

  always_ff @(posedge clock or negedge ck_rst) begin
    if (!ck_rst) begin
      led_q <= 4'b0001;
      r_q   <= PatOne;
      g_q   <= '0;
      b_q   <= '0;
    end else begin
      led_q <= 4'b0001 << mode_q;
      r_q   <= (color_q == COL_RED)   ? pat_q : '0;
      g_q   <= (color_q == COL_GREEN) ? pat_q : '0;
      b_q   <= (color_q == COL_BLUE)  ? pat_q : '0;
    end
  end

  assign o_led   = led_q;
  assign o_led_r = r_q;
  assign o_led_g = g_q;
  assign o_led_b = b_q;

endmodule

// File: tb/tb_pattern_leds.sv
// tb_pattern_leds: scoreboard bench for pattern_leds (N_LEDS=4, NB_COUNT=4,
// NB_SEL=2, DB_CYCLES=2). Expected output snapshots are queued when stimulus
// is applied and popped as the DUT outputs change.
module tb_pattern_leds;

  logic       clock = 1'b0;
  logic       ck_rst;
  logic [3:0] i_sw;
  logic [3:0] i_btn;
  logic [3:0] o_led;
  logic [3:0] o_led_r, o_led_g, o_led_b;

  always #5 clock = ~clock;

  pattern_leds #(
    .N_LEDS(4), .NB_SEL(2), .NB_COUNT(4), .NB_SW(4), .NB_BTN(4), .DB_CYCLES(2)
  ) dut (
    .clock  (clock),
    .ck_rst (ck_rst),
    .i_sw   (i_sw),
    .i_btn  (i_btn),
    .o_led  (o_led),
    .o_led_r(o_led_r),
    .o_led_g(o_led_g),
    .o_led_b(o_led_b)
  );

  typedef struct {
    string      tag;
    logic [3:0] led, r, g, b;
  } exp_t;

  exp_t       sb[$];
  logic [3:0] seq[$];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] outs();
    return {o_led, o_led_r, o_led_g, o_led_b};
  endfunction

  // col: 0 red, 1 green, 2 blue
  task automatic push(input string tag, input logic [3:0] led, input int col,
                      input logic [3:0] pat);
    exp_t e;
    e.tag = tag;
    e.led = led;
    e.r   = (col == 0) ? pat : 4'd0;
    e.g   = (col == 1) ? pat : 4'd0;
    e.b   = (col == 2) ? pat : 4'd0;
    sb.push_back(e);
  endtask

  task automatic push_seq(input string tag, input logic [3:0] led, input int col,
                          input logic [3:0] pats[$]);
    foreach (pats[k]) push($sformatf("%s%0d", tag, k), led, col, pats[k]);
  endtask

  task automatic cmp(input exp_t e);
    chk({e.tag, ".led"}, o_led,   e.led);
    chk({e.tag, ".r"},   o_led_r, e.r);
    chk({e.tag, ".g"},   o_led_g, e.g);
    chk({e.tag, ".b"},   o_led_b, e.b);
  endtask

  // Compare the head of the scoreboard against the present outputs
  task automatic check_now();
    exp_t e;
    if (sb.size() == 0) begin
      chk("sb_empty", 32'(sb.size()), 1);
    end else begin
      e = sb.pop_front();
      cmp(e);
    end
  endtask

  // First entry is the present output; each later entry is the next output
  // change. Spacing between changes (after the first) must equal period.
  task automatic drain(input int period);
    exp_t       e;
    logic [15:0] snap;
    int          n;
    int          idx;
    idx = 0;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      if (idx > 0) begin
        snap = outs();
        n = 0;
        while (outs() == snap && n < 64) begin
          @(negedge clock);
          n++;
        end
        if (outs() == snap) chk({e.tag, ".change"}, 32'(outs() != snap), 1);
        else if (idx > 1)   chk({e.tag, ".period"}, n, period);
      end
      cmp(e);
      idx++;
    end
  endtask

  task automatic press(input logic [3:0] mask, input int hold);
    @(negedge clock);
    i_btn = mask;
    repeat (hold) @(negedge clock);
    i_btn = 4'b0000;
    repeat (20) @(negedge clock);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    ck_rst = 1'b0;
    i_sw   = 4'b0000;
    i_btn  = 4'b0000;

    // Reset state
    #23;
    push("rst", 4'b0001, 0, 4'b0001);
    check_now();
    @(negedge clock);
    ck_rst = 1'b1;
    repeat (3) @(negedge clock);

    // SHIFT left, slowest speed: tick every 16
    i_sw = 4'b0111;
    seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    push_seq("shl", 4'b0001, 0, seq);
    drain(16);

    // SHIFT right, fastest speed: tick every 2
    i_sw = 4'b1001;
    seq = '{4'b0001, 4'b1000, 4'b0100, 4'b0010};
    push_seq("shr", 4'b0001, 0, seq);
    drain(2);
    i_sw = 4'b1000;

    // FLASH
    press(4'b0001, 20);
    push("m_flash", 4'b0010, 0, 4'b1111);
    check_now();
    i_sw = 4'b0011;
    seq = '{4'b1111, 4'b0000, 4'b1111, 4'b0000};
    push_seq("flash", 4'b0010, 0, seq);
    drain(4);
    i_sw = 4'b0010;

    // BOUNCE, dir switch set to 1 but ignored
    press(4'b0001, 20);
    push("m_bounce", 4'b0100, 0, 4'b0001);
    check_now();
    i_sw = 4'b1011;
    seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001};
    push_seq("bounce", 4'b0100, 0, seq);
    drain(4);
    i_sw = 4'b1010;

    // FILL dir=0, then dir flipped mid-animation
    press(4'b0001, 20);
    push("m_fill", 4'b1000, 0, 4'b0000);
    check_now();
    i_sw = 4'b0011;
    seq = '{4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b0000, 4'b0001};
    push_seq("fill0_", 4'b1000, 0, seq);
    drain(4);
    i_sw = 4'b1011;
    seq = '{4'b0001, 4'b1000, 4'b1100, 4'b1110, 4'b1111, 4'b0000, 4'b1000};
    push_seq("fill1_", 4'b1000, 0, seq);
    drain(4);
    i_sw = 4'b1010;

    // Green press: not visible within 4 edges, visible by 6
    @(negedge clock);
    i_btn = 4'b0100;
    push("g_pre", 4'b1000, 0, 4'b1000);
    push("g_post", 4'b1000, 1, 4'b1000);
    repeat (4) @(negedge clock);
    check_now();
    repeat (2) @(negedge clock);
    check_now();
    repeat (14) @(negedge clock);
    i_btn = 4'b0000;
    repeat (20) @(negedge clock);

    // Color priority and repeat presses
    press(4'b1010, 20);
    push("c_rb", 4'b1000, 0, 4'b1000);
    check_now();
    press(4'b1000, 20);
    push("c_b", 4'b1000, 2, 4'b1000);
    check_now();
    press(4'b1000, 20);
    push("c_bb", 4'b1000, 2, 4'b1000);
    check_now();
    press(4'b1100, 20);
    push("c_gb", 4'b1000, 1, 4'b1000);
    check_now();
    press(4'b0010, 20);
    push("c_r", 4'b1000, 0, 4'b1000);
    check_now();

    // Glitchy mode button: 1-cycle pulses never settle
    for (int k = 0; k < 10; k++) begin
      i_btn = (k % 2 == 0) ? 4'b0001 : 4'b0000;
      @(negedge clock);
    end
    i_btn = 4'b0000;
    repeat (20) @(negedge clock);
    push("glitch", 4'b1000, 0, 4'b1000);
    check_now();

    // Clean hold of DB_CYCLES+1 cycles: exactly one advance, FILL -> SHIFT
    press(4'b0001, 3);
    push("clean", 4'b0001, 0, 4'b0001);
    check_now();

    // Freeze with enable=0 while a color press still lands
    i_sw = 4'b0011;
    seq = '{4'b0001, 4'b0010, 4'b0100};
    push_seq("pre_frz", 4'b0001, 0, seq);
    drain(4);
    i_sw = 4'b0010;
    repeat (30) @(negedge clock);
    push("frz_a", 4'b0001, 0, 4'b0100);
    check_now();
    press(4'b0100, 20);
    repeat (30) @(negedge clock);
    push("frz_b", 4'b0001, 1, 4'b0100);
    check_now();

    // BOUNCE then asynchronous reset mid-animation
    press(4'b0001, 20);
    press(4'b0001, 20);
    push("m_b2", 4'b0100, 1, 4'b0001);
    check_now();
    i_sw = 4'b0001;
    seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    push_seq("b2_", 4'b0100, 1, seq);
    drain(2);
    @(posedge clock);
    #3;
    ck_rst = 1'b0;
    #1;
    push("rst_mid", 4'b0001, 0, 4'b0001);
    check_now();
    repeat (3) @(negedge clock);
    ck_rst = 1'b1;
    seq = '{4'b0001, 4'b0010, 4'b0100};
    push_seq("post_rst", 4'b0001, 0, seq);
    drain(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
